br_game_fsm: RTL and testbench

Parametrised game-flow controller for the BlockyRoads VGA game. It generalises the fixed five-obstacle, four-digit game loop into an N-obstacle, D-digit block. It sequences idle → play → explode → game-over, keeps a BCD running score and a BCD high score, and reports which obstacle caused the crash. It sits between the keyboard/collision logic (inputs) and the renderer and 7-segment driver (outputs).

---
 rtl/br_game_fsm.sv | 188 ++++++++++++++++++
 tb/tb_br_game_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/br_game_fsm.sv
// br_game_fsm - game-flow controller for BlockyRoads.
//   Sequences IDLE -> PLAY -> EXPLODE -> OVER. It keeps a saturating BCD
//   running score and a BCD high score, and latches the index of the
//   obstacle that caused the crash.
// Ports:
//   clk, clr (async, active-low)   clock / reset
//   start                          start/restart request (one cycle)
//   frame_tick                     one pulse per video frame
//   collide[NUM_OBS]               per-obstacle collision levels
//   state[2]                       0 IDLE, 1 PLAY, 2 EXPLODE, 3 OVER
//   scroll_en / btn_visible / explode_visible   renderer controls
//   hit_idx                        lowest colliding obstacle index
//   score / high_score             BCD, digit 0 in the LSBs
//   new_high                       one-cycle pulse on a high-score update
// Config macro: BR_HISCORE_EN builds the high-score register and comparator.
//   When it is undefined, high_score and new_high are tied to 0.
// All outputs are registered.
module br_game_fsm #(
  parameter int NUM_OBS        = 5,
  parameter int NUM_DIGITS     = 4,
  parameter int SCORE_DIV      = 30,
  parameter int EXPLODE_FRAMES = 60,
  localparam int HW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1,
  localparam int SW = 4 * NUM_DIGITS
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               frame_tick,
  input  logic [NUM_OBS-1:0] collide,
  output logic [1:0]         state,
  output logic               scroll_en,
  output logic               btn_visible,
  output logic               explode_visible,
  output logic [HW-1:0]      hit_idx,
  output logic [SW-1:0]      score,
  output logic [SW-1:0]      high_score,
  output logic               new_high
);
  localparam int FCW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int ECW = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic [FCW-1:0] FMAX = FCW'(SCORE_DIV - 1);
  localparam logic [ECW-1:0] EMAX = ECW'(EXPLODE_FRAMES - 1);
  localparam logic [SW-1:0]  SAT  = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, EXPL = 2'd2, OVER = 2'd3} st_e;

  st_e            state_q, state_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [ECW-1:0] expl_q, expl_d;
  logic [SW-1:0]  score_q, score_d;
  logic [HW-1:0]  hit_q, hit_d, low_idx;
  logic           expl_done;
  logic           scroll_q, scroll_d, btn_q, btn_d, boom_q, boom_d;

  // BCD +1 with ripple carry across the digits.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (c) begin
        if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Lowest set collide bit: scan downwards so the last match wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--)
      if (collide[i]) low_idx = HW'(i);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      expl_q   <= '0;
      score_q  <= '0;
      hit_q    <= '0;
      scroll_q <= 1'b0;
      btn_q    <= 1'b1;
      boom_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      expl_q   <= expl_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      scroll_q <= scroll_d;
      btn_q    <= btn_d;
      boom_q   <= boom_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    expl_d    = expl_q;
    score_d   = score_q;
    hit_d     = hit_q;
    expl_done = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          score_d = '0;
          frame_d = '0;
          expl_d  = '0;
        end
      end
      PLAY: begin
        // A collision beats a same-cycle tick: no score for that frame.
        if (|collide) begin
          state_d = EXPL;
          hit_d   = low_idx;
        end else if (frame_tick) begin
          if (frame_q == FMAX) begin
            frame_d = '0;
            if (score_q != SAT) score_d = bcd_inc(score_q);
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: begin
        if (frame_tick) begin
          if (expl_q == EMAX) begin
            state_d   = OVER;
            expl_d    = '0;
            expl_done = 1'b1;
          end else begin
            expl_d = expl_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs decoded from the next state so they register on the same edge.
  always_comb begin
    scroll_d = (state_d == PLAY);
    btn_d    = (state_d == IDLE) || (state_d == OVER);
    boom_d   = (state_d == EXPL);
  end

  assign state           = state_q;
  assign scroll_en       = scroll_q;
  assign btn_visible     = btn_q;
  assign explode_visible = boom_q;
  assign hit_idx         = hit_q;
  assign score           = score_q;

`ifdef BR_HISCORE_EN
  logic [SW-1:0] hs_q;
  logic          nh_q;
  logic          hs_upd;

  // BCD ordering matches binary ordering, so a plain compare is enough.
  assign hs_upd = expl_done && (score_q > hs_q);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hs_q <= '0;
      nh_q <= 1'b0;
    end else begin
      nh_q <= hs_upd;
      if (hs_upd) hs_q <= score_q;
    end
  end

  assign high_score = hs_q;
  assign new_high   = nh_q;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule

// File: tb/tb_br_game_fsm.sv
// Directed bench for br_game_fsm with SCORE_DIV=2 and EXPLODE_FRAMES=3.
// Inputs are driven and outputs sampled on the falling edge.
// High-score expectations follow BR_HISCORE_EN.
module tb_br_game_fsm;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic [4:0]  collide = '0;
  logic [1:0]  state;
  logic        scroll_en, btn_visible, explode_visible, new_high;
  logic [2:0]  hit_idx;
  logic [15:0] score, high_score;

  int n_chk = 0;
  int n_ok  = 0;

`ifdef BR_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  br_game_fsm #(.NUM_OBS(5), .NUM_DIGITS(4), .SCORE_DIV(2), .EXPLODE_FRAMES(3)) dut (
    .clk(clk), .clr(clr), .start(start), .frame_tick(frame_tick), .collide(collide),
    .state(state), .scroll_en(scroll_en), .btn_visible(btn_visible),
    .explode_visible(explode_visible), .hit_idx(hit_idx), .score(score),
    .high_score(high_score), .new_high(new_high)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic crash(input logic [4:0] c);
    collide = c;
    cyc(1);
    collide = '0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_btn", btn_visible, 1);
    chk("rst_scroll", scroll_en, 0);
    chk("rst_boom", explode_visible, 0);
    chk("rst_hit", hit_idx, 0);
    chk("rst_score", score, 0);
    chk("rst_hs", high_score, 0);
    chk("rst_nh", new_high, 0);
    clr = 1'b1;
    // frame_tick in IDLE is ignored
    ticks(3);
    chk("idle_tick", state, 0);

    // Game 1
    pulse_start();
    chk("g1_state", state, 1);
    chk("g1_scroll", scroll_en, 1);
    chk("g1_btn", btn_visible, 0);
    chk("g1_score0", score, 16'h0000);
    ticks(19);
    chk("g1_score9", score, 16'h0009);
    ticks(1);
    chk("g1_carry", score, 16'h0010);
    ticks(1);                       // frame counter now 1
    chk("g1_div", score, 16'h0010);
    // Collision and tick in the same cycle: collision wins
    collide = 5'b10100;
    frame_tick = 1'b1;
    cyc(1);
    collide = '0;
    frame_tick = 1'b0;
    chk("g1_expl", state, 2);
    chk("g1_hit", hit_idx, 2);
    chk("g1_boom", explode_visible, 1);
    chk("g1_noinc", score, 16'h0010);
    chk("g1_scroll_off", scroll_en, 0);
    pulse_start();                  // ignored in EXPLODE
    crash(5'b00001);                // ignored in EXPLODE
    chk("g1_ign_start", state, 2);
    chk("g1_ign_coll", hit_idx, 2);
    ticks(2);
    chk("g1_expl2", state, 2);
    ticks(1);
    chk("g1_over", state, 3);
    chk("g1_nh", new_high, HS ? 1 : 0);
    chk("g1_hs", high_score, HS ? 16'h0010 : 16'h0000);
    chk("g1_btn_over", btn_visible, 1);
    cyc(1);
    chk("g1_nh_once", new_high, 0);
    ticks(4);                       // ignored in OVER
    chk("g1_over_hold", state, 3);
    chk("g1_over_score", score, 16'h0010);

    // Game 2: start together with a tick, lower score
    start = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    start = 1'b0;
    frame_tick = 1'b0;
    chk("g2_state", state, 1);
    chk("g2_score0", score, 16'h0000);
    chk("g2_hit_hold", hit_idx, 2);
    ticks(4);
    chk("g2_score", score, 16'h0002);
    crash(5'b00011);
    chk("g2_hit", hit_idx, 0);
    ticks(3);
    chk("g2_over", state, 3);
    chk("g2_nh", new_high, 0);
    chk("g2_hs", high_score, HS ? 16'h0010 : 16'h0000);

    // Game 3: higher score
    pulse_start();
    ticks(30);
    chk("g3_score", score, 16'h0015);
    crash(5'b10000);
    chk("g3_hit", hit_idx, 4);
    ticks(3);
    chk("g3_nh", new_high, HS ? 1 : 0);
    chk("g3_hs", high_score, HS ? 16'h0015 : 16'h0000);

    // Game 4: saturation, then async reset mid-EXPLODE
    pulse_start();
    ticks(19998);
    chk("g4_max", score, 16'h9999);
    ticks(10);
    chk("g4_sat", score, 16'h9999);
    crash(5'b01000);
    chk("g4_hit", hit_idx, 3);
    chk("g4_expl", state, 2);
    ticks(1);
    #2 clr = 1'b0;
    #1;
    chk("clr_state", state, 0);
    chk("clr_btn", btn_visible, 1);
    chk("clr_boom", explode_visible, 0);
    chk("clr_scroll", scroll_en, 0);
    chk("clr_hit", hit_idx, 0);
    chk("clr_score", score, 0);
    chk("clr_hs", high_score, 0);
    chk("clr_nh", new_high, 0);
    cyc(1);
    clr = 1'b1;
    cyc(1);
    chk("post_clr", state, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
